// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryption core: one round per clock over a 128-bit state,
// NR = 10/12/14 rounds, valid/ready handshakes on both sides.
module aes_encrypt_iter #(
    parameter  int NR    = 10,
    localparam int KEY_W = 128 * (NR + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    input  logic [KEY_W-1:0] in_w,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             busy
);

    if (NR != 10 && NR != 12 && NR != 14) begin : g_nr_check
        $error("aes_encrypt_iter: NR must be 10, 12 or 14");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             fsm_r;
    logic [127:0]       state_r;
    logic [KEY_W-1:0]   key_r;
    logic [3:0]         round_cnt_r;
    logic [127:0]       out_data_r;
    logic               out_valid_r;
    logic               busy_r;

    logic               in_ready_s;
    logic               accept_s;
    logic [127:0]       sb_s;
    logic [127:0]       sr_s;
    logic [127:0]       mc_s;
    logic [127:0]       rk_s;
    logic [127:0]       rk_arr_s [16];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            p  = p ^ (aa & {8{bb[0]}});
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (a^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign sb_s[8*i +: 8] = sbox(state_r[8*i +: 8]);
    end

    // Byte k = 4*col + row sits at [127-8k -: 8]; row r rotates left by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr_s[127-8*(4*c+r) -: 8] = sb_s[127-8*(4*((c+r)%4)+r) -: 8];
        end
        assign mc_s[127-32*c -: 32] = mix_col(sr_s[127-32*c -: 32]);
    end

    for (genvar r = 0; r < 16; r++) begin : g_rk
        if (r <= NR) begin : g_used
            assign rk_arr_s[r] = key_r[KEY_W-1-128*r -: 128];
        end else begin : g_unused
            assign rk_arr_s[r] = 128'h0;
        end
    end

    assign rk_s      = rk_arr_s[round_cnt_r];
    assign accept_s  = in_valid & in_ready_s;
    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;

    // Input readiness: idle, or done and the result is leaving this cycle.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else begin
            case (fsm_r)
                S_IDLE:  in_ready_s = 1'b1;
                S_DONE:  in_ready_s = out_ready;
                default: in_ready_s = 1'b0;
            endcase
        end
    end

    // Control FSM and round datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r       <= S_IDLE;
            state_r     <= 128'h0;
            key_r       <= '0;
            round_cnt_r <= 4'd0;
            out_data_r  <= 128'h0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (fsm_r)
                S_IDLE: begin
                    if (accept_s) begin
                        key_r       <= in_w;
                        state_r     <= in_data ^ in_w[KEY_W-1 -: 128];
                        round_cnt_r <= 4'd1;
                        busy_r      <= 1'b1;
                        fsm_r       <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (round_cnt_r == 4'(NR)) begin
                        out_data_r  <= sr_s ^ rk_s;
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                        fsm_r       <= S_DONE;
                    end else begin
                        state_r     <= mc_s ^ rk_s;
                        round_cnt_r <= round_cnt_r + 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        if (accept_s) begin
                            key_r       <= in_w;
                            state_r     <= in_data ^ in_w[KEY_W-1 -: 128];
                            round_cnt_r <= 4'd1;
                            busy_r      <= 1'b1;
                            fsm_r       <= S_ROUND;
                        end else begin
                            fsm_r <= S_IDLE;
                        end
                    end
                end
                default: begin
                    fsm_r       <= S_IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter: NR=10/12/14 instances checked against
// a byte-array AES reference model plus FIPS-197 known answers.
module tb_aes_encrypt_iter;

    logic         clk;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_data   [3];
    logic [1919:0] in_w     [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];
    logic         busy      [3];

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] sbox_t [256];
    logic [7:0] exp_t  [256];
    logic [7:0] log_t  [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    aes_encrypt_iter #(.NR(10)) u_nr10 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_w(in_w[0][1407:0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]));
    aes_encrypt_iter #(.NR(12)) u_nr12 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_w(in_w[1][1663:0]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]));
    aes_encrypt_iter #(.NR(14)) u_nr14 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_w(in_w[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2]));

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box from exp/log tables over generator 3.
    task automatic build_sbox();
        logic [7:0] x;
        logic [7:0] inv;
        logic [7:0] ix;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = x;
            log_t[x] = 8'(i);
            x = x ^ xt(x);
        end
        for (int a = 0; a < 256; a++) begin
            if (a == 0) inv = 8'h00;
            else begin
                ix  = 8'((255 - int'(log_t[a])) % 255);
                inv = exp_t[ix];
            end
            sbox_t[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    // Key schedule; key left-aligned in 256 bits, round r at [128*(nr+1)-1-128r -: 128].
    function automatic logic [1919:0] model_expand(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   tmp;
        logic [7:0]    rc;
        logic [1919:0] res;
        int nr;
        nr  = nk + 6;
        rc  = 8'h01;
        res = '0;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) w[i] = 32'(key >> (224 - 32 * i));
            else begin
                tmp = w[i-1];
                if (i % nk == 0) begin
                    tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                    rc  = xt(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    tmp = sub_word(tmp);
                end
                w[i] = w[i-nk] ^ tmp;
            end
        end
        for (int r = 0; r <= nr; r++)
            res = res | ({1792'h0, w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} << (128 * (nr - r)));
        return res;
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt,
                                                   input logic [1919:0] sched, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] rk;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = 8'(pt >> (120 - 8 * i));
        for (int r = 0; r <= nr; r++) begin
            if (r > 0) begin
                for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int w = 0; w < 4; w++) t[4*c+w] = s[4*((c+w)%4)+w];
                if (r < nr) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                    end
                end
                s = t;
            end
            rk = 128'(sched >> (128 * (nr - r)));
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ 8'(rk >> (120 - 8 * i));
        end
        res = '0;
        for (int i = 0; i < 16; i++) res = {res[119:0], s[i]};
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [1919:0] rand_w();
        logic [1919:0] v;
        v = '0;
        for (int i = 0; i < 60; i++) v = {v[1887:0], $urandom()};
        return v;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; in_data[k] = '0; in_w[k] = '0; out_ready[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (in_ready[k] !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready[%0d]: got %b want 0", k, in_ready[k]); end
            n_cmp++; if (out_valid[k] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid[%0d]: got %b want 0", k, out_valid[k]); end
            n_cmp++; if (busy[k] !== 1'b0) begin n_bad++; $display("FAIL reset_busy[%0d]: got %b want 0", k, busy[k]); end
            n_cmp++; if (out_data[k] !== 128'h0) begin n_bad++; $display("FAIL reset_out_data[%0d]: got %h want 0", k, out_data[k]); end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (in_ready[k] !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready[%0d]: got %b want 1", k, in_ready[k]); end
        end
        @(posedge clk); #1;
    endtask

    // One block through instance k with out_ready=1; checks latency and result.
    task automatic do_block(input int k, input logic [127:0] pt, input logic [1919:0] sched,
                            input logic [127:0] exp_ct, input bit scramble, input string tag);
        int nr;
        int lat;
        bit seen;
        nr = 10 + 2 * k;
        in_valid[k] = 1'b1; in_data[k] = pt; in_w[k] = sched; out_ready[k] = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready[k] !== 1'b1) begin n_bad++; $display("FAIL %s_in_ready: got %b want 1", tag, in_ready[k]); end
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        if (scramble) begin in_data[k] = rand128(); in_w[k] = rand_w(); end
        n_cmp++; if (busy[k] !== 1'b1) begin n_bad++; $display("FAIL %s_busy: got %b want 1", tag, busy[k]); end
        lat = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid[k] === 1'b1) seen = 1'b1;
            else if (scramble) begin in_data[k] = rand128(); in_w[k] = rand_w(); end
        end
        n_cmp++; if (lat != nr) begin n_bad++; $display("FAIL %s_latency: got %0d want %0d", tag, lat, nr); end
        n_cmp++; if (out_data[k] !== exp_ct) begin n_bad++; $display("FAIL %s_data: got %h want %h", tag, out_data[k], exp_ct); end
        n_cmp++; if (busy[k] !== 1'b0) begin n_bad++; $display("FAIL %s_busy_done: got %b want 0", tag, busy[k]); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid[k] !== 1'b0) begin n_bad++; $display("FAIL %s_drain: got %b want 0", tag, out_valid[k]); end
    endtask

    task automatic test_fips_b();
        do_block(0, 128'h3243f6a8885a308d313198a2e0370734,
                 model_expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4),
                 128'h3925841d02dc09fbdc118597196a0b32, 1'b0, "fips_b");
    endtask

    task automatic test_fips_c();
        logic [127:0] pt;
        pt = 128'h00112233445566778899aabbccddeeff;
        do_block(0, pt, model_expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4),
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, "fips_c128");
        do_block(1, pt, model_expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6),
                 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 1'b0, "fips_c192");
        do_block(2, pt, model_expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8),
                 128'h8ea2b7ca516745bfeafc49904b496089, 1'b0, "fips_c256");
    endtask

    task automatic test_isolation();
        do_block(0, 128'h3243f6a8885a308d313198a2e0370734,
                 model_expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4),
                 128'h3925841d02dc09fbdc118597196a0b32, 1'b1, "isolation");
    endtask

    task automatic test_backpressure();
        logic [127:0]  pa, pb, ea, eb;
        logic [1919:0] sa, sb;
        int cnt;
        pa = rand128(); pb = rand128();
        sa = model_expand({rand128(), 128'h0}, 4);
        sb = model_expand({rand128(), 128'h0}, 4);
        ea = model_encrypt(pa, sa, 10);
        eb = model_encrypt(pb, sb, 10);
        out_ready[0] = 1'b0; in_valid[0] = 1'b1; in_data[0] = pa; in_w[0] = sa;
        @(negedge clk);
        n_cmp++; if (in_ready[0] !== 1'b1) begin n_bad++; $display("FAIL bp_accept_a: got %b want 1", in_ready[0]); end
        @(posedge clk); #1;
        in_data[0] = pb; in_w[0] = sb;
        cnt = 0;
        while (out_valid[0] !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            n_cmp++; if (in_ready[0] !== 1'b0) begin n_bad++; $display("FAIL bp_round_in_ready: got %b want 0", in_ready[0]); end
            @(posedge clk); #1;
            cnt++;
        end
        n_cmp++; if (cnt != 10) begin n_bad++; $display("FAIL bp_latency_a: got %0d want 10", cnt); end
        repeat (5) begin
            @(negedge clk);
            n_cmp++; if (out_valid[0] !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid: got %b want 1", out_valid[0]); end
            n_cmp++; if (out_data[0] !== ea) begin n_bad++; $display("FAIL bp_hold_data: got %h want %h", out_data[0], ea); end
            n_cmp++; if (in_ready[0] !== 1'b0) begin n_bad++; $display("FAIL bp_stall_in_ready: got %b want 0", in_ready[0]); end
            @(posedge clk); #1;
            cnt++;
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready[0] !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready[0]); end
        @(posedge clk); #1;
        cnt++;
        in_valid[0] = 1'b0;
        n_cmp++; if (out_valid[0] !== 1'b0) begin n_bad++; $display("FAIL bp_dual_hs_valid: got %b want 0", out_valid[0]); end
        n_cmp++; if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL bp_dual_hs_busy: got %b want 1", busy[0]); end
        while (out_valid[0] !== 1'b1 && cnt < 80) begin
            @(posedge clk); #1;
            cnt++;
        end
        n_cmp++; if (out_data[0] !== eb) begin n_bad++; $display("FAIL bp_data_b: got %h want %h", out_data[0], eb); end
        @(posedge clk); #1;
        cnt++;
        n_cmp++; if (out_valid[0] !== 1'b0) begin n_bad++; $display("FAIL bp_drain_b: got %b want 0", out_valid[0]); end
        n_cmp++; if (cnt != 2 * 11 + 5) begin n_bad++; $display("FAIL bp_total_cycles: got %0d want %0d", cnt, 2 * 11 + 5); end
    endtask

    task automatic test_reset_mid();
        bit pulsed;
        in_valid[0] = 1'b1; out_ready[0] = 1'b1;
        in_data[0] = 128'h3243f6a8885a308d313198a2e0370734;
        in_w[0] = model_expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready[0] !== 1'b0) begin n_bad++; $display("FAIL rmid_in_ready_rst: got %b want 0", in_ready[0]); end
        n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL rmid_busy_rst: got %b want 0", busy[0]); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready[0] !== 1'b1) begin n_bad++; $display("FAIL rmid_in_ready_after: got %b want 1", in_ready[0]); end
        pulsed = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid[0] !== 1'b0) pulsed = 1'b1;
        end
        n_cmp++; if (pulsed) begin n_bad++; $display("FAIL rmid_no_pulse: got 1 want 0"); end
        test_fips_b();
    endtask

    task automatic test_back_to_back();
        logic [127:0]  pts    [20];
        logic [1919:0] scheds [20];
        logic [127:0]  expq   [$];
        logic [127:0]  want;
        int nxt, got, cyc, last;
        bit acc;
        for (int i = 0; i < 20; i++) begin
            pts[i]    = rand128();
            scheds[i] = model_expand({rand128(), rand128()}, 8);
        end
        nxt = 0; got = 0; cyc = 0; last = -1;
        out_ready[2] = 1'b1; in_valid[2] = 1'b1; in_data[2] = pts[0]; in_w[2] = scheds[0];
        while (got < 20 && cyc < 600) begin
            @(negedge clk);
            acc = (in_valid[2] === 1'b1) && (in_ready[2] === 1'b1);
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                expq.push_back(model_encrypt(pts[nxt], scheds[nxt], 14));
                nxt++;
                if (nxt < 20) begin in_data[2] = pts[nxt]; in_w[2] = scheds[nxt]; end
                else in_valid[2] = 1'b0;
            end
            if (out_valid[2] === 1'b1) begin
                want = (expq.size() > 0) ? expq.pop_front() : 'x;
                n_cmp++; if (out_data[2] !== want) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", got, out_data[2], want); end
                if (last >= 0) begin
                    n_cmp++; if (cyc - last != 15) begin n_bad++; $display("FAIL b2b_interval[%0d]: got %0d want 15", got, cyc - last); end
                end
                last = cyc;
                got++;
            end
        end
        n_cmp++; if (got != 20) begin n_bad++; $display("FAIL b2b_count: got %0d want 20", got); end
        in_valid[2] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        build_sbox();
        test_reset();
        test_fips_b();
        test_fips_c();
        test_isolation();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_encrypt_iter.md
Name: aes_encrypt_iter

Overview:
- Iterative AES block-encryption core: one round per clock over a single 128-bit state register, reusing the team's SubBytes/ShiftRows/MixColumns/AddRoundKey round primitives.
- Generalises the fixed 10-round unrolled encrypt datapath: round count is parametrised to cover AES-128, AES-192 and AES-256 (NR = 10/12/14).
- Adds valid/ready handshakes on input and output, and latches the expanded key schedule per block.
- Sits between the key-expansion block, which supplies the expanded schedule, and the cipher-mode/stream logic.

Parameters:
- NR, 10, number of rounds; legal values are 10, 12 and 14; any other value is an elaboration error.
- KEY_W, 128*(NR+1), width of the expanded key schedule; derived from NR, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  plaintext block and key schedule are valid
- in_ready  output  1  core can accept a block this cycle
- in_data  input  128  plaintext, byte 0 in [127:120]
- in_w  input  KEY_W  expanded key schedule; round key r = in_w[KEY_W-1-128*r -: 128]
- out_valid  output  1  ciphertext valid
- out_ready  input  1  downstream accepts ciphertext
- out_data  output  128  ciphertext
- busy  output  1  high while in state ROUND

Behaviour:
- Reset (async, active-high): state=IDLE, state_reg=0, key_reg=0, round_cnt=0, out_data=0, out_valid=0, busy=0. in_ready=0 while rst is high.
- Accept: in_valid & in_ready at a rising edge.
  - key_reg <= in_w.
  - state_reg <= in_data ^ round key 0.
  - round_cnt <= 1.
  - FSM -> ROUND.
  - in_data/in_w are don't-care after acceptance; the core never re-samples them mid-block.
- FSM states: IDLE, ROUND, DONE.
  - IDLE: in_ready=1, out_valid=0. Accept -> ROUND.
  - ROUND: in_ready=0, busy=1. Each cycle applies round r=round_cnt using round key r from key_reg.
    - r < NR: state_reg <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), key r); round_cnt++.
    - r == NR (final round, no MixColumns): out_data <= AddRoundKey(ShiftRows(SubBytes(state_reg)), key NR); out_valid <= 1; -> DONE.
  - DONE: out_valid=1; out_data held stable until out_ready.
    - in_ready = out_ready (combinational).
    - out_ready & !in_valid: out_valid <= 0 -> IDLE.
    - out_ready & in_valid (simultaneous output handshake and accept): new block accepted per the Accept rule, out_valid <= 0 -> ROUND. No bubble cycle.
    - !out_ready: stall indefinitely in DONE; in_valid ignored.
- Latency: out_valid rises exactly NR clock edges after the accepting edge (10/12/14).
- Throughput: one block per NR+1 cycles when out_ready is held high and in_valid is back-to-back.
- out_data changes only on the final-round edge; it is not cleared on output handshake.
- round_cnt width: 4 bits. It never exceeds NR, so no wrap-around occurs.
- Reset mid-operation (in ROUND or DONE): block aborted, no out_valid pulse, returns to IDLE; in_ready=1 on the first cycle after rst deasserts.
- Byte/column order matches the existing round primitives: column 0 = [127:96].

Test Plan:
- NR=10, FIPS-197 App. B: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c (expanded by bench model), out_ready=1 -> out_valid exactly 10 cycles after accept, out_data=3925841d02dc09fbdc118597196a0b32.
- NR=10/12/14, FIPS-197 App. C: pt 00112233445566778899aabbccddeeff, keys 000102..0f / ..17 / ..1f -> 69c4e0d86a7b0430d8cdb78070b4c55a / dda97ca4864cdfe06eaf70a0ec0d7191 / 8ea2b7ca516745bfeafc49904b496089, at latency 10/12/14.
- Backpressure: out_ready=0 for 5 cycles after out_valid; in_valid held high with a second block -> out_data stable, in_ready=0 throughout; on out_ready=1 both handshakes occur in the same cycle; second result appears NR cycles later; total 2 blocks in 2*(NR+1)+5 cycles.
- Input isolation: randomise in_data/in_w every cycle after the accepting edge -> ciphertext still equals the App. B value.
- Reset mid-round: assert rst at round 5 for 1 cycle -> out_valid never pulses, in_ready=1 on the next cycle; a subsequent App. B block yields the correct result.
- Back-to-back stream: 20 random blocks with out_ready=1, NR=14 -> all match the reference model, one result every 15 cycles.
